// File: rtl/ysyx_22050612_rf_defs_pkg.sv
// Shared constants for the multi-port register file: zero-register index,
// default geometry and the write-port priority rule.
package ysyx_22050612_rf_defs;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int ZERO_REG       = 0;

  // When set, the highest-numbered write port wins on a same-address conflict.
  localparam bit WPRIO_HIGH_INDEX = 1'b1;

  // Maps loop step n to a port index so that the last port visited has the highest priority.
  function automatic int prio_order(input int n, input int nw);
    return WPRIO_HIGH_INDEX ? n : (nw - 1 - n);
  endfunction

endpackage

// File: rtl/ysyx_22050612_rf_rdport.sv
// One combinational read port: write-to-read bypass, busy masking for a
// completing producer, and the hardwired zero register.
module ysyx_22050612_rf_rdport
  import ysyx_22050612_rf_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NW         = 2
) (
  input  logic [ADDR_WIDTH-1:0]    raddr,
  input  logic [DATA_WIDTH-1:0]    stored,
  input  logic                     stored_busy,
  input  logic [NW-1:0]            wen,
  input  logic [NW*ADDR_WIDTH-1:0] waddr,
  input  logic [NW*DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rbusy
);

  logic hit;
  int   idx;

  always_comb begin
    rdata = stored;
    hit   = 1'b0;
    idx   = 0;
    for (int n = 0; n < NW; n++) begin
      idx = prio_order(n, NW);
      if (wen[idx] && (waddr[idx*ADDR_WIDTH +: ADDR_WIDTH] == raddr)) begin
        rdata = wdata[idx*DATA_WIDTH +: DATA_WIDTH];
        hit   = 1'b1;
      end
    end
    rbusy = stored_busy & ~hit;
    if (raddr == ADDR_WIDTH'(ZERO_REG)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050612_regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard,
// fixed-priority writes and asynchronous active-low clear.
module ysyx_22050612_regfile_mp
  import ysyx_22050612_rf_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR         = 2,
  parameter int NW         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NW-1:0]            wen,
  input  logic [NW*ADDR_WIDTH-1:0] waddr,
  input  logic [NW*DATA_WIDTH-1:0] wdata,
  input  logic [NR*ADDR_WIDTH-1:0] raddr,
  output logic [NR*DATA_WIDTH-1:0] rdata,
  output logic [NR-1:0]            rbusy,
  input  logic                     mark_en,
  input  logic [ADDR_WIDTH-1:0]    mark_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] rf [DEPTH-1:1];
  logic [DEPTH-1:0]      busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < DEPTH; k++) rf[k] <= '0;
    end else begin
      for (int n = 0; n < NW; n++) begin
        if (wen[prio_order(n, NW)] &&
            waddr[prio_order(n, NW)*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX)
          rf[waddr[prio_order(n, NW)*ADDR_WIDTH +: ADDR_WIDTH]] <=
            wdata[prio_order(n, NW)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A mark issued in the same cycle as a completing write wins: a newer producer owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wen[i] && waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX)
          busy[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
      end
      if (mark_en && mark_addr != ZERO_IDX)
        busy[mark_addr] <= 1'b1;
    end
  end

  assign any_busy = |busy;

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] stored;

    assign ra     = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign stored = (ra == ZERO_IDX) ? '0 : rf[ra];

    ysyx_22050612_rf_rdport #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NW        (NW)
    ) u_rdport (
      .raddr      (ra),
      .stored     (stored),
      .stored_busy(busy[ra]),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata),
      .rdata      (rdata[p*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy      (rbusy[p])
    );
  end

endmodule

// File: tb/tb_ysyx_22050612_regfile_mp.sv
// Self-checking bench for ysyx_22050612_regfile_mp: a vector table replayed
// through a scoreboard queue, then hand-written asynchronous-reset sequences.
module tb_ysyx_22050612_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic [1:0]      wen;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]      rbusy;
  logic            mark_en;
  logic [AW-1:0]   mark_addr;
  logic            any_busy;

  ysyx_22050612_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(2), .NW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .any_busy (any_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]    wen;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          me;
    logic [AW-1:0] ma;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    eb;
    logic          ea;
  } vec_t;

  typedef struct {
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    eb;
    logic          ea;
  } exp_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [1:0] w, input int a0, input logic [DW-1:0] d0,
                              input int a1, input logic [DW-1:0] d1, input int r0, input int r1,
                              input logic me, input int ma, input logic [DW-1:0] e0,
                              input logic [DW-1:0] e1, input logic [1:0] eb, input logic ea);
    vec_t v;
    v.wen = w;   v.wa0 = AW'(a0); v.wd0 = d0; v.wa1 = AW'(a1); v.wd1 = d1;
    v.ra0 = AW'(r0); v.ra1 = AW'(r1); v.me = me; v.ma = AW'(ma);
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    wen       = v.wen;
    waddr     = {v.wa1, v.wa0};
    wdata     = {v.wd1, v.wd0};
    raddr     = {v.ra1, v.ra0};
    mark_en   = v.me;
    mark_addr = v.ma;
    e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.ea = v.ea;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int step);
    exp_t e;
    if (sb.size() == 0) begin
      check($sformatf("sb_empty[%0d]", step), 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("rdata0[%0d]", step), rdata[DW-1:0], e.e0);
    check($sformatf("rdata1[%0d]", step), rdata[2*DW-1:DW], e.e1);
    check($sformatf("rbusy[%0d]", step), DW'(rbusy), DW'(e.eb));
    check($sformatf("any_busy[%0d]", step), DW'(any_busy), DW'(e.ea));
  endtask

  initial begin
    //           wen    wa0 wd0           wa1 wd1      ra0 ra1 me  ma  e0            e1            eb     ea
    tbl[0]  = mk(2'b00, 0,  64'h0,        0,  64'h0,    5, 31, 0,  0,  64'h0,        64'h0,        2'b00, 0);
    tbl[1]  = mk(2'b01, 3,  64'hDEADBEEF, 0,  64'h0,    3,  0, 0,  0,  64'hDEADBEEF, 64'h0,        2'b00, 0);
    tbl[2]  = mk(2'b00, 3,  64'hBAD,      0,  64'h0,    3,  7, 0,  0,  64'hDEADBEEF, 64'h0,        2'b00, 0);
    tbl[3]  = mk(2'b10, 0,  64'h0,        7,  64'h1234, 3,  7, 0,  0,  64'hDEADBEEF, 64'h1234,     2'b00, 0);
    tbl[4]  = mk(2'b01, 0,  64'hFFFF,     0,  64'h0,    0,  7, 0,  0,  64'h0,        64'h1234,     2'b00, 0);
    tbl[5]  = mk(2'b00, 0,  64'h0,        0,  64'h0,    0,  3, 0,  0,  64'h0,        64'hDEADBEEF, 2'b00, 0);
    tbl[6]  = mk(2'b11, 9,  64'hAAAA,     9,  64'h5555, 9,  9, 0,  0,  64'h5555,     64'h5555,     2'b00, 0);
    tbl[7]  = mk(2'b00, 0,  64'h0,        0,  64'h0,    9,  7, 0,  0,  64'h5555,     64'h1234,     2'b00, 0);
    tbl[8]  = mk(2'b00, 0,  64'h0,        0,  64'h0,    4,  9, 1,  4,  64'h0,        64'h5555,     2'b00, 0);
    tbl[9]  = mk(2'b00, 0,  64'h0,        0,  64'h0,    4,  9, 0,  0,  64'h0,        64'h5555,     2'b01, 1);
    tbl[10] = mk(2'b01, 4,  64'h77,       0,  64'h0,    4,  4, 0,  0,  64'h77,       64'h77,       2'b00, 1);
    tbl[11] = mk(2'b00, 0,  64'h0,        0,  64'h0,    4,  4, 0,  0,  64'h77,       64'h77,       2'b00, 0);
    tbl[12] = mk(2'b01, 4,  64'h88,       0,  64'h0,    4,  0, 1,  4,  64'h88,       64'h0,        2'b00, 0);
    tbl[13] = mk(2'b00, 0,  64'h0,        0,  64'h0,    4,  0, 0,  0,  64'h88,       64'h0,        2'b01, 1);
    tbl[14] = mk(2'b00, 0,  64'h0,        0,  64'h0,    0,  4, 1,  0,  64'h0,        64'h88,       2'b10, 1);
    tbl[15] = mk(2'b11, 1,  64'h11,       2,  64'h22,   1,  2, 1,  2,  64'h11,       64'h22,       2'b00, 1);
    tbl[16] = mk(2'b00, 0,  64'h0,        0,  64'h0,    2,  1, 0,  0,  64'h22,       64'h11,       2'b01, 1);

    rst_n = 1'b0; wen = '0; waddr = '0; wdata = '0; raddr = '0;
    mark_en = 1'b0; mark_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(tbl[k]);
      @(negedge clk);
      checkOutput(k);
      @(posedge clk);
      #1;
    end

    // Regs 1..3 hold 0x11, 0x22, 0xDEADBEEF and busy[2] is set; clear between edges.
    wen = '0; mark_en = 1'b0; raddr = {AW'(2), AW'(3)};
    #2;
    check("pre_rst_rdata0", rdata[DW-1:0], 64'hDEADBEEF);
    check("pre_rst_rbusy1", DW'(rbusy[1]), 64'd1);
    check("pre_rst_any_busy", DW'(any_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rdata0", rdata[DW-1:0], 64'h0);
    check("rst_rdata1", rdata[2*DW-1:DW], 64'h0);
    check("rst_rbusy", DW'(rbusy), 64'd0);
    check("rst_any_busy", DW'(any_busy), 64'd0);
    wen = 2'b01; waddr = {AW'(0), AW'(3)}; wdata = {64'h0, 64'h5A5A};
    @(posedge clk);
    #1 wen = '0; rst_n = 1'b1; raddr = {AW'(1), AW'(3)};
    #2;
    check("post_rst_lost_write", rdata[DW-1:0], 64'h0);
    check("post_rst_reg1", rdata[2*DW-1:DW], 64'h0);

    wen = 2'b01; waddr = {AW'(0), AW'(5)}; wdata = {64'h0, 64'h55};
    @(posedge clk);
    #1 wen = '0; raddr = {AW'(0), AW'(5)};
    #2;
    check("first_write_after_rst", rdata[DW-1:0], 64'h55);
    check("first_write_any_busy", DW'(any_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_regfile_mp.md
# ysyx_22050612_regfile_mp

Multi-port integer register file with a busy scoreboard. It replaces the single-write, two-read register file in the NPC core. It gives NR combinational read ports, NW write ports with fixed priority, write-to-read bypass, a hardwired zero register and asynchronous clear. A per-register busy bit tracks in-flight producers so that decode can stall on RAW hazards without a separate scoreboard block.

## Interface
Parameters:
- ADDR_WIDTH, 5: register index width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 64: register width.
- NR, 2: number of read ports (1..4).
- NW, 2: number of write ports (1..2); a higher index has higher priority.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wen  in  NW  per-port write enable.
- waddr  in  NW*ADDR_WIDTH  write index; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NW*DATA_WIDTH  write data, packed the same way.
- raddr  in  NR*ADDR_WIDTH  read index per port.
- rdata  out  NR*DATA_WIDTH  read data per port (combinational).
- rbusy  out  NR  register-pending flag per read port (combinational).
- mark_en  in  1  set the busy bit of mark_addr (an instruction is issued with this destination).
- mark_addr  in  ADDR_WIDTH  destination being marked.
- any_busy  out  1  OR of all busy bits; reset value 0.

## Operation
Storage and reset:
- Storage is 2**ADDR_WIDTH-1 registers; index 0 is not stored.
- rst_n low asynchronously clears every register to 0 and every busy bit to 0.

Register 0:
- Reads of index 0 return 0 with rbusy=0.
- Writes to index 0 are dropped.
- A mark of index 0 is ignored.

Writes:
- At the clock edge, for each enabled port with a nonzero address, rf[waddr] <= wdata.
- Same-cycle writes to the same address: the higher port index wins. The lower port's data is discarded.

Read bypass:
- If any enabled write port targets a nonzero raddr this cycle, rdata returns that port's wdata (highest-index match) instead of the stored value.
- Every read port bypasses independently.

Busy scoreboard:
- A write with a nonzero address clears busy[waddr] at the edge.
- mark_en sets busy[mark_addr] at the edge.
- Mark and clear of the same address in one cycle: the mark wins and busy stays 1 (a new producer supersedes the old one).
- rbusy[i] = busy[raddr_i] & ~(an enabled write to raddr_i this cycle). A producer completing this cycle is therefore visible as not busy, and its data arrives through the bypass.

Other rules:
- No width conversion; data passes unmodified.
- No display or debug side effects in the synthesizable body.

## Timing
- Read latency is 0 cycles; rdata and rbusy are combinational from raddr, wen, waddr and wdata.
- Write latency is 1 edge; the stored value is visible without bypass from the next cycle.
- busy is updated 1 edge after mark_en or the write.
- rst_n assertion mid-operation takes effect immediately: rdata of every stored register becomes 0 and any_busy falls the same cycle without a clock.
- Deassertion is synchronous to use. The first write is accepted at the first rising edge after rst_n is high.
- Writes presented during reset are lost.
- Combinational path raddr -> rdata must not loop through wen. The design contains no latches.

## Structure
- Shared package/header ysyx_22050612_rf_defs holds:
  - ZERO_REG index constant;
  - default ADDR_WIDTH and DATA_WIDTH;
  - the priority rule as a documented constant (WPRIO_HIGH_INDEX).
- Sub-module ysyx_22050612_rf_rdport, instantiated NR times:
  - inputs: one raddr, the stored value, all write ports;
  - outputs: bypassed rdata and rbusy with the zero-register rule.
  - The top holds the storage array, write loop, busy vector and any_busy.

## Test plan
1. Reset then read: rst_n=0 for 2 cycles, then raddr0=5, raddr1=31 -> rdata=0 on both ports, rbusy=0, any_busy=0.
2. Write then read next cycle: wen0=1, waddr0=3, wdata0=0xDEAD_BEEF. The following cycle raddr0=3 -> rdata0=0xDEAD_BEEF.
3. Same-cycle bypass and zero register:
   - wen1=1, waddr1=7, wdata1=0x1234 with raddr1=7 in the same cycle -> rdata1=0x1234.
   - A write of 0xFFFF to x0 -> x0 still reads 0.
4. Port conflict: both ports write address 9 (port0 0xAAAA, port1 0x5555) -> a read of 9 returns 0x5555 both same-cycle and next cycle.
5. Scoreboard:
   - mark_en with mark_addr=4 -> next cycle rbusy=1 for raddr=4 and any_busy=1.
   - Then write 4 with 0x77 -> rbusy=0 during that cycle with rdata=0x77; busy clear after the edge.
   - Mark and write of 4 in one cycle -> busy stays 1.
6. Asynchronous reset mid-stream: regs 1..3 hold nonzero values and busy[2]=1. Drop rst_n between edges -> rdata=0 and any_busy=0 before the next edge; a write issued during reset is absent afterwards.
